// File: rtl/muldiv_seq.sv
// Multi-cycle multiply/divide sequencer owning the HI/LO pair.
// Shift-add multiply and restoring divide, one step per cycle, WIDTH steps per op.
`ifndef ALU_CONTROL_LENGTH
`define ALU_CONTROL_LENGTH 4
`endif
`ifndef ALU_CONTROL_MULT
`define ALU_CONTROL_MULT   8
`endif
`ifndef ALU_CONTROL_MULTU
`define ALU_CONTROL_MULTU  9
`endif
`ifndef ALU_CONTROL_DIVU
`define ALU_CONTROL_DIVU   10
`endif
`ifndef ALU_CONTROL_MTHI
`define ALU_CONTROL_MTHI   11
`endif
`ifndef ALU_CONTROL_MTLO
`define ALU_CONTROL_MTLO   12
`endif

module muldiv_seq #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = `ALU_CONTROL_LENGTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              md_valid,
    input  logic [CTRL_W-1:0] md_op,
    input  logic [WIDTH-1:0]  src_a,
    input  logic [WIDTH-1:0]  src_b,
    input  logic              rd_req,
    input  logic              flush,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo,
    output logic              busy,
    output logic              done,
    output logic              stall
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [CTRL_W-1:0] OP_MULT  = CTRL_W'(`ALU_CONTROL_MULT);
    localparam logic [CTRL_W-1:0] OP_MULTU = CTRL_W'(`ALU_CONTROL_MULTU);
    localparam logic [CTRL_W-1:0] OP_DIVU  = CTRL_W'(`ALU_CONTROL_DIVU);
    localparam logic [CTRL_W-1:0] OP_MTHI  = CTRL_W'(`ALU_CONTROL_MTHI);
    localparam logic [CTRL_W-1:0] OP_MTLO  = CTRL_W'(`ALU_CONTROL_MTLO);

    logic [0:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               is_div_q, is_div_d;
    logic               sign_q, sign_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift, div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, step_next, result;

    assign a_abs = src_a[WIDTH-1] ? (~src_a + 1'b1) : src_a;
    assign b_abs = src_b[WIDTH-1] ? (~src_b + 1'b1) : src_b;

    // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? b_q : {WIDTH{1'b0}})};
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        div_shift = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, b_q};
        div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
        step_next = is_div_q ? div_next : mul_next;
        result    = sign_q ? (~step_next + 1'b1) : step_next;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (md_valid && !flush) begin
                    case (md_op)
                        OP_MULT: begin
                            acc_d    = {{WIDTH{1'b0}}, b_abs};
                            b_d      = a_abs;
                            sign_d   = src_a[WIDTH-1] ^ src_b[WIDTH-1];
                            is_div_d = 1'b0;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = ST_RUN;
                        end
                        OP_MULTU: begin
                            acc_d    = {{WIDTH{1'b0}}, src_b};
                            b_d      = src_a;
                            sign_d   = 1'b0;
                            is_div_d = 1'b0;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = ST_RUN;
                        end
                        OP_DIVU: begin
                            acc_d    = {{WIDTH{1'b0}}, src_a};
                            b_d      = src_b;
                            sign_d   = 1'b0;
                            is_div_d = 1'b1;
                            cnt_d    = CNT_W'(WIDTH);
                            state_d  = ST_RUN;
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            default: begin
                if (flush) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    acc_d = step_next;
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        hi_d    = result[2*WIDTH-1:WIDTH];
                        lo_d    = result[WIDTH-1:0];
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = (state_q == ST_RUN);
    assign done  = done_q;
    assign stall = busy & (md_valid | rd_req);

endmodule
